// File: rtl/debounce_ctrl.sv
// Single-channel push-button debouncer: 2-FF synchroniser, sample-tick divider,
// and a qualification FSM that emits a clean level plus one-cycle edge pulses.
module debounce_ctrl #(
  parameter int TICK_DIV   = 250000,
  parameter int STABLE_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic enable,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic sample_tick
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int SCNT_W = $clog2(STABLE_CNT + 1);

  localparam logic [CNT_W-1:0]  TICK_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  TICK_ONE    = CNT_W'(1);
  localparam logic [SCNT_W-1:0] STABLE_LAST = SCNT_W'(STABLE_CNT - 1);
  localparam logic [SCNT_W-1:0] SCNT_ONE    = SCNT_W'(1);

  localparam logic [1:0] S_LOW      = 2'd0;
  localparam logic [1:0] S_RISE_CHK = 2'd1;
  localparam logic [1:0] S_HIGH     = 2'd2;
  localparam logic [1:0] S_FALL_CHK = 2'd3;

  logic              s1;
  logic              btn_s;
  logic [CNT_W-1:0]  tick_cnt;
  logic [1:0]        state;
  logic [SCNT_W-1:0] stab_cnt;
  logic              rise_q;
  logic              fall_q;

  // The synchroniser keeps running even while enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn_in;
      btn_s <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (enable) begin
      if (tick_cnt == TICK_LAST)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + TICK_ONE;
    end
  end

  assign sample_tick = enable && (tick_cnt == TICK_LAST);

  // Stable count holds the number of agreeing samples already seen in a check
  // state; reaching STABLE_CNT on the current tick commits the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOW;
      stab_cnt  <= '0;
      btn_level <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sample_tick) begin
        case (state)
          S_LOW: begin
            if (btn_s) begin
              state    <= S_RISE_CHK;
              stab_cnt <= SCNT_ONE;
            end
          end
          S_RISE_CHK: begin
            if (!btn_s) begin
              state    <= S_LOW;
              stab_cnt <= '0;
            end else if (stab_cnt == STABLE_LAST) begin
              state     <= S_HIGH;
              stab_cnt  <= '0;
              btn_level <= 1'b1;
              rise_q    <= 1'b1;
            end else begin
              stab_cnt <= stab_cnt + SCNT_ONE;
            end
          end
          S_HIGH: begin
            if (!btn_s) begin
              state    <= S_FALL_CHK;
              stab_cnt <= SCNT_ONE;
            end
          end
          S_FALL_CHK: begin
            if (btn_s) begin
              state    <= S_HIGH;
              stab_cnt <= '0;
            end else if (stab_cnt == STABLE_LAST) begin
              state     <= S_LOW;
              stab_cnt  <= '0;
              btn_level <= 1'b0;
              fall_q    <= 1'b1;
            end else begin
              stab_cnt <= stab_cnt + SCNT_ONE;
            end
          end
          default: begin
            state    <= S_LOW;
            stab_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign btn_rise = rise_q & enable;
  assign btn_fall = fall_q & enable;

endmodule

// File: tb/tb_debounce_ctrl.sv
// Directed bench for debounce_ctrl with TICK_DIV=4, STABLE_CNT=3.
// Cycle 0 is the first cycle after rst deasserts; ticks land on cycles 3, 7, 11, ...
module tb_debounce_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic enable = 1'b1;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic sample_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  debounce_ctrl #(.TICK_DIV(4), .STABLE_CNT(3)) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .enable(enable),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One clock with rst high; afterwards we sit in cycle 0.
  task automatic do_reset(input logic held_btn);
    rst    = 1'b1;
    btn_in = held_btn;
    enable = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    for (int c = 0; c <= 8; c++) begin
      #1;
      checks++;
      if (btn_level !== 1'b0 || btn_rise !== 1'b0 || btn_fall !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cyc=%0d got lvl/rise/fall=%0b%0b%0b exp=000",
                 c, btn_level, btn_rise, btn_fall);
      end
      checks++;
      if (sample_tick !== ((c % 4) == 3)) begin
        errors++;
        $display("[TB] FAIL reset_tick cyc=%0d got=%0b exp=%0b", c, sample_tick, (c % 4) == 3);
      end
      next_cycle();
    end
  endtask

  // Press at cycle 0, release at cycle 16: rise at 12, fall at 28.
  task automatic test_clean_press_release();
    do_reset(1'b0);
    for (int c = 0; c <= 34; c++) begin
      btn_in = (c < 16);
      #1;
      checks++;
      if (btn_level !== (c >= 12 && c < 28)) begin
        errors++;
        $display("[TB] FAIL press_level cyc=%0d got=%0b exp=%0b", c, btn_level, c >= 12 && c < 28);
      end
      checks++;
      if (btn_rise !== (c == 12)) begin
        errors++;
        $display("[TB] FAIL press_rise cyc=%0d got=%0b exp=%0b", c, btn_rise, c == 12);
      end
      checks++;
      if (btn_fall !== (c == 28)) begin
        errors++;
        $display("[TB] FAIL release_fall cyc=%0d got=%0b exp=%0b", c, btn_fall, c == 28);
      end
      next_cycle();
    end
  endtask

  // High for cycles 0-8 aborts at tick 11; a new press from cycle 12 must
  // start counting from scratch (ticks 15,19,23 -> level at 24).
  task automatic test_glitch();
    do_reset(1'b0);
    for (int c = 0; c <= 30; c++) begin
      btn_in = (c <= 8) || (c >= 12);
      #1;
      checks++;
      if (btn_level !== (c >= 24)) begin
        errors++;
        $display("[TB] FAIL glitch_level cyc=%0d got=%0b exp=%0b", c, btn_level, c >= 24);
      end
      checks++;
      if (btn_rise !== (c == 24)) begin
        errors++;
        $display("[TB] FAIL glitch_rise cyc=%0d got=%0b exp=%0b", c, btn_rise, c == 24);
      end
      next_cycle();
    end
  endtask

  // enable low 5-20: counter holds at 1, ticks resume at 23, rise at 28.
  task automatic test_enable_freeze();
    logic exp_tick;
    do_reset(1'b1);
    for (int c = 0; c <= 34; c++) begin
      enable = !(c >= 5 && c <= 20);
      #1;
      exp_tick = (c == 3) || (c >= 23 && ((c - 23) % 4) == 0);
      checks++;
      if (sample_tick !== exp_tick) begin
        errors++;
        $display("[TB] FAIL freeze_tick cyc=%0d got=%0b exp=%0b", c, sample_tick, exp_tick);
      end
      checks++;
      if (btn_rise !== (c == 28)) begin
        errors++;
        $display("[TB] FAIL freeze_rise cyc=%0d got=%0b exp=%0b", c, btn_rise, c == 28);
      end
      checks++;
      if (btn_level !== (c >= 28)) begin
        errors++;
        $display("[TB] FAIL freeze_level cyc=%0d got=%0b exp=%0b", c, btn_level, c >= 28);
      end
      next_cycle();
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_press();
    do_reset(1'b1);
    while (cyc < 14) next_cycle();
    checks++;
    if (btn_level !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_pre_level got=%0b exp=1", btn_level);
    end
    do_reset(1'b1);
    for (int c = 0; c <= 16; c++) begin
      #1;
      checks++;
      if (btn_level !== (c >= 12)) begin
        errors++;
        $display("[TB] FAIL midrst_level cyc=%0d got=%0b exp=%0b", c, btn_level, c >= 12);
      end
      checks++;
      if (btn_rise !== (c == 12) || btn_fall !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_pulse cyc=%0d got rise/fall=%0b%0b exp=%0b0",
                 c, btn_rise, btn_fall, c == 12);
      end
      next_cycle();
    end
  endtask

  // Toggle every 3 cycles (starting low) for 40 cycles, then hold high.
  // Each bounce burst reaches count 2 then aborts; the settled press
  // qualifies on ticks 43,47,51 -> rise at 52.
  task automatic test_back_to_back();
    do_reset(1'b0);
    for (int c = 0; c <= 56; c++) begin
      btn_in = (c >= 40) ? 1'b1 : (((c / 3) % 2) == 1);
      #1;
      checks++;
      if (btn_rise !== (c == 52) || btn_fall !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bounce_pulse cyc=%0d got rise/fall=%0b%0b exp=%0b0",
                 c, btn_rise, btn_fall, c == 52);
      end
      checks++;
      if (btn_level !== (c >= 52)) begin
        errors++;
        $display("[TB] FAIL bounce_level cyc=%0d got=%0b exp=%0b", c, btn_level, c >= 52);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_clean_press_release();
    test_glitch();
    test_enable_freeze();
    test_reset_mid_press();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_ctrl.md
Name: debounce_ctrl

Overview:
- Single-channel switch-debounce controller for the push-button input path on the Spartan-6 board.
- Synchronises the raw pin, generates a periodic sample tick from the system clock, and runs a qualification FSM that accepts a level change only after STABLE_CNT consecutive agreeing samples.
- Drives a clean level plus one-cycle rise/fall pulses to downstream gating logic.

Parameters:
- TICK_DIV, 250000, clock cycles per sample tick (must be ≥2).
- STABLE_CNT, 4, consecutive agreeing samples required to accept a change (must be ≥2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous switch pin.
- enable  input  1  1 = run; 0 = freeze tick counter and FSM.
- btn_level  output  1  debounced level, registered.
- btn_rise  output  1  one-cycle pulse when btn_level goes 0→1.
- btn_fall  output  1  one-cycle pulse when btn_level goes 1→0.
- sample_tick  output  1  debug strobe; high on tick cycles.

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high (rst sampled on rising clk edge).
- Reset values: sync flops 0, tick counter 0, FSM S_LOW, stable count 0, btn_level 0, btn_rise 0, btn_fall 0. sample_tick is therefore 0.
- Synchroniser: 2-FF chain btn_in→s1→btn_s. The FSM sees only btn_s.
- Tick counter: width clog2(TICK_DIV).
  - Counter is 0 in the first cycle after rst deasserts.
  - Increments each cycle while enable=1.
  - Wraps TICK_DIV-1→0.
  - sample_tick = enable & (counter==TICK_DIV-1), combinational decode.
- enable=0: counter holds its value, sample_tick=0, FSM and stable count hold, btn_rise/btn_fall forced 0. The synchroniser keeps running.
- FSM (evaluated only on cycles with sample_tick=1; otherwise holds):
  - S_LOW: btn_s=1 → S_RISE_CHK, cnt=1. Else stay.
  - S_RISE_CHK: btn_s=1 and cnt+1==STABLE_CNT → S_HIGH, cnt=0, btn_level←1, btn_rise←1. btn_s=1 otherwise → cnt+1. btn_s=0 → S_LOW, cnt=0.
  - S_HIGH: btn_s=0 → S_FALL_CHK, cnt=1. Else stay.
  - S_FALL_CHK: btn_s=0 and cnt+1==STABLE_CNT → S_LOW, cnt=0, btn_level←0, btn_fall←1. btn_s=0 otherwise → cnt+1. btn_s=1 → S_HIGH, cnt=0.
- Pulses: btn_rise and btn_fall are high for exactly one cycle, the cycle after the qualifying tick. They are never high simultaneously.
- Latency: btn_level changes one cycle after the STABLE_CNT-th consecutive agreeing tick. Worst case from a clean edge on btn_in is 2 + TICK_DIV·STABLE_CNT + 1 cycles.
- Stable count width: clog2(STABLE_CNT+1). It never exceeds STABLE_CNT-1 outside transitions.
- Reset mid-operation (any state, including btn_level=1 with the button held):
  - All state returns to reset values. No btn_fall pulse is generated.
  - A held button must re-qualify through S_RISE_CHK and then produces a fresh btn_rise.
- Bounce during a check state: any disagreeing sample aborts to the origin state. A partial count is never carried over.
- An input change between ticks is invisible. Only btn_s on tick cycles matters.

Test Plan (TICK_DIV=4, STABLE_CNT=3; cycle 0 = first cycle after rst deasserts; ticks at cycles 3, 7, 11, 15…):
- Clean press: btn_in=1 from cycle 0 → btn_s=1 by cycle 2; FSM goes S_RISE_CHK at 3 and counts at 7; btn_level=1 and btn_rise=1 in cycle 12 only; btn_fall stays 0.
- Glitch rejection: btn_in=1 for cycles 0–8, then 0 → btn_s=1 at the tick-3 and tick-7 samples, then 0 at tick 11 → FSM returns to S_LOW after tick 11; btn_level=0 and btn_rise=0 throughout.
- Clean release: from S_HIGH (level=1) drop btn_in and hold 0 → btn_fall=1 for exactly one cycle and btn_level=0, appearing the cycle after the third consecutive 0 tick.
- Enable freeze: press as in the clean-press case, drive enable=0 during cycles 5–20, then re-enable → no sample_tick in 5–20; counter resumes from its held value; rise completes two ticks after re-enable; exactly one btn_rise.
- Reset mid-press: reach btn_level=1, assert rst for one cycle with btn_in still 1 → outputs 0 the cycle after; no btn_fall; btn_level=1 and btn_rise again at cycle 12 relative to the new cycle 0.
- Bounce train: toggle btn_in every 3 cycles for 40 cycles, then hold 1 → no pulses during bouncing; a single btn_rise 3 ticks after the level settles.
